// File: rtl/exu_seq_if.sv
// Handshake bundle between IDU (master), the sequential EXU (slave) and WBU.
//  Request side : in_valid/in_ready, op, use_imm, src1, src2, imm
//  Response side: out_valid/out_ready, result, carry, overflow, illegal
interface exu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic             use_imm;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, op, use_imm, src1, src2, imm, out_ready,
    input  in_ready, out_valid, result, carry, overflow, illegal
  );

  modport slave (
    input  in_valid, op, use_imm, src1, src2, imm, out_ready,
    output in_ready, out_valid, result, carry, overflow, illegal
  );
endinterface

// File: rtl/exu_seq.sv
// Sequential execution unit: one op per in_valid/in_ready transaction,
// registered result held until out_ready. ALU ops complete in one cycle,
// MUL iterates shift-add for WIDTH cycles.
//  clk  : clock, rising edge
//  rst  : asynchronous reset, active high
//  bus  : exu_seq_if.slave (request in, result/flags out)
module exu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  exu_seq_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_CMPU = 4'd8;
  localparam logic [3:0] OP_CMPS = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [WIDTH-1:0] CMP_GT = WIDTH'(2);
  localparam logic [WIDTH-1:0] CMP_LT = WIDTH'(4);

  state_t           state;
  logic             out_valid, carry, overflow, illegal;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [SH_W-1:0]  cnt;

  // Operand select and single-cycle datapath (evaluated on accept only)
  logic [WIDTH-1:0]        a, b;
  logic signed [WIDTH-1:0] a_s;
  logic [SH_W-1:0]         sh;
  logic [WIDTH:0]          add_s, sub_s;
  logic                    add_v, sub_v, eq, lt_u, lt_s, mul_go;
  logic [WIDTH-1:0]        nx_res, acc_nx;
  logic                    nx_c, nx_v, nx_ill;

  assign a     = bus.src1;
  assign b     = bus.use_imm ? bus.imm : bus.src2;
  assign a_s   = a;
  assign sh    = b[SH_W-1:0];
  assign add_s = {1'b0, a} + {1'b0, b};
  // SUB as a + ~b + 1 so the carry-out is the no-borrow flag
  assign sub_s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign add_v = (a[WIDTH-1] == b[WIDTH-1]) & (add_s[WIDTH-1] ^ a[WIDTH-1]);
  assign sub_v = (a[WIDTH-1] ^ b[WIDTH-1]) & (sub_s[WIDTH-1] ^ a[WIDTH-1]);
  assign eq    = (sub_s[WIDTH-1:0] == '0);
  assign lt_u  = ~sub_s[WIDTH];
  assign lt_s  = sub_s[WIDTH-1] ^ sub_v;

  assign mul_go = MUL_EN && (bus.op == OP_MUL);
  assign acc_nx = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    nx_res = '0;
    nx_c   = 1'b0;
    nx_v   = 1'b0;
    nx_ill = 1'b0;
    case (bus.op)
      OP_ADD:  begin nx_res = add_s[WIDTH-1:0]; nx_c = add_s[WIDTH]; nx_v = add_v; end
      OP_SUB:  begin nx_res = sub_s[WIDTH-1:0]; nx_c = sub_s[WIDTH]; nx_v = sub_v; end
      OP_AND:  nx_res = a & b;
      OP_OR:   nx_res = a | b;
      OP_XOR:  nx_res = a ^ b;
      OP_SLL:  nx_res = a << sh;
      OP_SRL:  nx_res = a >> sh;
      OP_SRA:  nx_res = WIDTH'(a_s >>> sh);
      OP_CMPU: begin
        nx_res = eq ? '0 : (lt_u ? CMP_LT : CMP_GT);
        nx_c   = sub_s[WIDTH];
      end
      OP_CMPS: begin
        nx_res = eq ? '0 : (lt_s ? CMP_LT : CMP_GT);
        nx_c   = sub_s[WIDTH];
        nx_v   = sub_v;
      end
      // MUL reaching here means the multiplier is not built
      default: nx_ill = 1'b1;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.carry     = carry;
  assign bus.overflow  = overflow;
  assign bus.illegal   = illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (mul_go) begin
              state  <= BUSY;
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= '0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= nx_res;
              carry     <= nx_c;
              overflow  <= nx_v;
              illegal   <= nx_ill;
            end
          end
        end
        BUSY: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last iteration folds straight into the result register
          if (cnt == SH_W'(WIDTH-1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= acc_nx;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            cnt       <= '0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exu_seq.sv
module tb_exu_seq;
  typedef logic [34:0] exp_t; // {illegal, overflow, carry, result}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exu_seq_if #(.WIDTH(32)) bus ();
  exu_seq_if #(.WIDTH(32)) bus0 ();

  exu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  exu_seq #(.WIDTH(32), .MUL_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: outcome of one operation from the opcode table
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit mul_en);
    logic [32:0] d;
    logic [32:0] s;
    logic [63:0] p;
    logic        sv, dv;
    s  = {1'b0, a} + {1'b0, b};
    d  = {1'b0, a} + {1'b0, ~b} + 33'd1;
    sv = (a[31] == b[31]) && (s[31] != a[31]);
    dv = (a[31] != b[31]) && (d[31] != a[31]);
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return {1'b0, sv, s[32], s[31:0]};
      4'd1:  return {1'b0, dv, d[32], d[31:0]};
      4'd2:  return {3'b000, a & b};
      4'd3:  return {3'b000, a | b};
      4'd4:  return {3'b000, a ^ b};
      4'd5:  return {3'b000, a << b[4:0]};
      4'd6:  return {3'b000, a >> b[4:0]};
      4'd7:  return {3'b000, 32'($signed(a) >>> b[4:0])};
      4'd8:  return {1'b0, 1'b0, d[32], (a == b) ? 32'd0 : (a > b) ? 32'd2 : 32'd4};
      4'd9:  return {1'b0, dv, d[32],
                     (a == b) ? 32'd0 : ($signed(a) > $signed(b)) ? 32'd2 : 32'd4};
      4'd10: return mul_en ? {3'b000, p[31:0]} : {3'b100, 32'd0};
      default: return {3'b100, 32'd0};
    endcase
  endfunction

  // Transaction-level model of the MUL_EN=1 unit
  bit   m_ready = 1'b1;
  bit   m_valid = 1'b0;
  int   m_wait  = 0;
  exp_t m_out   = '0;
  exp_t pend    = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ready = 1'b1; m_valid = 1'b0; m_wait = 0; m_out = '0;
      end else if (m_ready && bus.in_valid) begin
        pend    = model(bus.op, bus.src1, bus.use_imm ? bus.imm : bus.src2, 1'b1);
        m_ready = 1'b0;
        if (bus.op == 4'd10) m_wait = 32;
        else begin m_valid = 1'b1; m_out = pend; end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_valid = 1'b1; m_out = pend; end
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("handshake", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, m_ready, m_valid});
        if (m_valid)
          chk("output", {29'd0, bus.illegal, bus.overflow, bus.carry, bus.result}, {29'd0, m_out});
      end
    end
  end

  // Issue one op, check latency and literal expectation, hold off out_ready
  task automatic run_op(input string nm, input logic [3:0] op, input bit uimm,
                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] im,
                        input exp_t e, input int lat, input int hold);
    int n;
    @(negedge clk);
    bus.op = op; bus.use_imm = uimm; bus.src1 = s1; bus.src2 = s2; bus.imm = im;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.src1 = 32'hDEADBEEF; bus.src2 = 32'h13572468; bus.imm = 32'hA5A5A5A5;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat));
    chk({nm, " value"}, {29'd0, bus.illegal, bus.overflow, bus.carry, bus.result}, {29'd0, e});
    if (hold > 0) begin
      // A new request while the result is pending must be ignored
      bus.op = 4'd0; bus.src1 = 32'd5; bus.in_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk({nm, " held"}, {28'd0, bus.out_valid, bus.illegal, bus.overflow, bus.carry, bus.result},
          {28'd0, 1'b1, e});
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    chk({nm, " release"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.use_imm = 1'b0;
    bus.src1 = '0; bus.src2 = '0; bus.imm = '0;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.op = '0; bus0.use_imm = 1'b0;
    bus0.src1 = '0; bus0.src2 = '0; bus0.imm = '0;
    #1;
    chk("reset state", {28'd0, bus.in_ready, bus.out_valid, bus.illegal, bus.overflow, bus.carry, bus.result},
        {28'd0, 1'b1, 1'b0, 35'd0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("add_imm",  4'd0, 1'b1, 32'hFFFFFFFF, 32'h00000055, 32'h1, {3'b001, 32'h0}, 1, 0);
    run_op("sub",      4'd1, 1'b0, 32'h80000000, 32'h1, 32'h0, {3'b011, 32'h7FFFFFFF}, 1, 0);
    run_op("cmps",     4'd9, 1'b0, 32'h80000000, 32'h1, 32'h0, {3'b011, 32'h4}, 1, 0);
    run_op("cmpu",     4'd8, 1'b0, 32'h80000000, 32'h1, 32'h0, {3'b001, 32'h2}, 1, 0);
    run_op("sra",      4'd7, 1'b0, 32'h80000010, 32'h24, 32'h0, {3'b000, 32'hF8000001}, 1, 0);
    run_op("sll",      4'd5, 1'b0, 32'h80000010, 32'h24, 32'h0, {3'b000, 32'h00000100}, 1, 0);
    run_op("srl",      4'd6, 1'b1, 32'h80000010, 32'h0, 32'h24, {3'b000, 32'h08000001}, 1, 0);
    run_op("and",      4'd2, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, {3'b000, 32'h00F000F0}, 1, 0);
    run_op("or",       4'd3, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, {3'b000, 32'hFFF0FFF0}, 1, 0);
    run_op("xor",      4'd4, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, {3'b000, 32'hFF00FF00}, 1, 2);
    run_op("add_ovf",  4'd0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0, {3'b010, 32'h80000000}, 1, 0);
    run_op("cmps_eq",  4'd9, 1'b0, 32'h5, 32'h5, 32'h0, {3'b001, 32'h0}, 1, 0);
    run_op("cmps_gt",  4'd9, 1'b0, 32'h1, 32'hFFFFFFFF, 32'h0, {3'b000, 32'h2}, 1, 0);
    run_op("mul",      4'd10, 1'b0, 32'h12345678, 32'h10, 32'h0, {3'b000, 32'h23456780}, 33, 5);
    run_op("mul_ones", 4'd10, 1'b1, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, {3'b000, 32'h1}, 33, 0);
    run_op("illegal",  4'd12, 1'b0, 32'h1234, 32'h5678, 32'h0, {3'b100, 32'h0}, 1, 0);

    // Multiplier not built: MUL reports illegal in one cycle
    @(negedge clk);
    bus0.op = 4'd10; bus0.src1 = 32'h3; bus0.src2 = 32'h7; bus0.in_valid = 1'b1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    chk("mul_dis", {28'd0, bus0.in_ready, bus0.out_valid, bus0.illegal, bus0.overflow, bus0.carry, bus0.result},
        {28'd0, 1'b0, 1'b1, 3'b100, 32'h0});
    @(negedge clk); bus0.out_ready = 1'b1;
    @(posedge clk); #1; bus0.out_ready = 1'b0;
    chk("mul_dis release", {62'd0, bus0.in_ready, bus0.out_valid}, 64'b10);

    // Reset pulse in the middle of a multiply discards it
    @(negedge clk);
    bus.op = 4'd10; bus.use_imm = 1'b0; bus.src1 = 32'h7; bus.src2 = 32'h9; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst mid-mul", {28'd0, bus.in_ready, bus.out_valid, bus.illegal, bus.overflow, bus.carry, bus.result},
        {28'd0, 1'b1, 1'b0, 35'd0});
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("after rst", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);

    run_op("post_rst", 4'd0, 1'b0, 32'h10, 32'h20, 32'h0, {3'b000, 32'h30}, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
